// File: rtl/verinject_fault_sequencer.sv
// rtl/verinject_fault_sequencer.sv - one-shot fault descriptor sequencer driving verinject__injector_state
// Counts down a delay, drives the target bit index for a duration window, then reports done/aborted.
module verinject_fault_sequencer #(
   parameter logic [31:0] IDLE_STATE  = 32'hFFFF_FFFF,
   parameter int          DELAY_WIDTH = 32,
   parameter int          DUR_WIDTH   = 16,
   parameter int          COUNT_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [31:0]            cfg_target,
   input  logic [DELAY_WIDTH-1:0] cfg_delay,
   input  logic [DUR_WIDTH-1:0]   cfg_duration,
   input  logic                   abort,
   output logic [31:0]            verinject__injector_state,
   output logic                   busy,
   output logic                   injecting,
   output logic                   done,
   output logic                   aborted,
   output logic [COUNT_WIDTH-1:0] inject_count
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ARMED     = 2'd1,
      ST_INJECTING = 2'd2
   } state_t;

   localparam logic [DELAY_WIDTH-1:0] DLY_ONE   = DELAY_WIDTH'(1);
   localparam logic [DUR_WIDTH-1:0]   DUR_ONE   = DUR_WIDTH'(1);
   localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

   state_t                 state_q, state_d;
   logic [DELAY_WIDTH-1:0] dly_cnt_q, dly_cnt_d;
   logic [DUR_WIDTH-1:0]   dur_cnt_q, dur_cnt_d;
   logic [DUR_WIDTH-1:0]   dur_len_q, dur_len_d;
   logic [31:0]            target_q, target_d;
   logic [31:0]            bus_q, bus_d;
   logic                   done_q, done_d;
   logic                   aborted_q, aborted_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         dly_cnt_q <= '0;
         dur_cnt_q <= '0;
         dur_len_q <= '0;
         target_q  <= '0;
         bus_q     <= IDLE_STATE;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         dly_cnt_q <= dly_cnt_d;
         dur_cnt_q <= dur_cnt_d;
         dur_len_q <= dur_len_d;
         target_q  <= target_d;
         bus_q     <= bus_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         count_q   <= count_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      dly_cnt_d = dly_cnt_q;
      dur_cnt_d = dur_cnt_q;
      dur_len_d = dur_len_q;
      target_d  = target_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      count_d   = count_q;
      case (state_q)
         ST_IDLE: begin
            if (cfg_valid) begin
               target_d  = cfg_target;
               dur_len_d = cfg_duration;
               dly_cnt_d = cfg_delay;
               state_d   = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (abort) begin
               state_d   = ST_IDLE;
               aborted_d = 1'b1;
            end else if (dly_cnt_q == '0) begin
               state_d   = ST_INJECTING;
               dur_cnt_d = (dur_len_q == '0) ? '0 : dur_len_q - DUR_ONE;
            end else begin
               dly_cnt_d = dly_cnt_q - DLY_ONE;
            end
         end
         ST_INJECTING: begin
            if (abort) begin
               state_d   = ST_IDLE;
               aborted_d = 1'b1;
            end else if (dur_cnt_q == '0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               if (count_q != COUNT_MAX) count_d = count_q + COUNT_ONE;
            end else begin
               dur_cnt_d = dur_cnt_q - DUR_ONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Bus follows the next state so the window aligns with the state register.
      bus_d = (state_d == ST_INJECTING) ? target_d : IDLE_STATE;
   end

   assign cfg_ready                 = (state_q == ST_IDLE);
   assign busy                      = (state_q != ST_IDLE);
   assign injecting                 = (state_q == ST_INJECTING);
   assign verinject__injector_state = bus_q;
   assign done                      = done_q;
   assign aborted                   = aborted_q;
   assign inject_count              = count_q;

endmodule

// File: tb/tb_verinject_fault_sequencer.sv
// tb/tb_verinject_fault_sequencer.sv - vector table, random descriptors and corner sequences for the sequencer
module tb_verinject_fault_sequencer;

   localparam logic [31:0] IDLE_V = 32'hFFFF_FFFF;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [31:0]   cfg_target = '0;
   logic [31:0]   cfg_delay = '0;
   logic [15:0]   cfg_duration = '0;
   logic          abort = 1'b0;
   logic [31:0]   bus;
   logic          busy, injecting, done, aborted;
   logic [CW-1:0] inject_count;

   int n_pass  = 0;
   int n_total = 0;
   int exp_cnt = 0;

   verinject_fault_sequencer #(
      .IDLE_STATE(IDLE_V), .DELAY_WIDTH(32), .DUR_WIDTH(16), .COUNT_WIDTH(CW)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_target(cfg_target), .cfg_delay(cfg_delay), .cfg_duration(cfg_duration),
      .abort(abort), .verinject__injector_state(bus),
      .busy(busy), .injecting(injecting), .done(done), .aborted(aborted),
      .inject_count(inject_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] target;
      int          delay;
      int          duration;
      int          abort_k;
      bit          abort0;
      int          exp_start;
      int          exp_len;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic chk_outputs(input string tag, input logic [31:0] e_bus, input bit e_busy,
                              input bit e_inj, input bit e_done, input bit e_abt);
      chk({tag, " bus"},       bus,                  e_bus);
      chk({tag, " busy"},      32'(busy),            32'(e_busy));
      chk({tag, " injecting"}, 32'(injecting),       32'(e_inj));
      chk({tag, " cfg_ready"}, 32'(cfg_ready),       32'(!e_busy));
      chk({tag, " done"},      32'(done),            32'(e_done));
      chk({tag, " aborted"},   32'(aborted),         32'(e_abt));
      chk({tag, " count"},     32'(inject_count),    32'(exp_cnt));
   endtask

   task automatic idle_cycles(input int n);
      cfg_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clock); #1;
         chk_outputs("idle", IDLE_V, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   // Cycle k means the cycle following acceptance edge E0+k.
   task automatic run_desc(input logic [31:0] t, input int d, input int du, input int ak,
                           input bit ab0, input int st, input int ln);
      int last;
      cfg_valid    = 1'b1;
      cfg_target   = t;
      cfg_delay    = d;
      cfg_duration = 16'(du);
      abort        = ab0;
      @(posedge clock); #1;
      cfg_valid    = 1'b0;
      cfg_target   = $urandom;
      cfg_delay    = $urandom_range(0, 3);
      cfg_duration = 16'($urandom_range(0, 3));
      last = (ak != 0) ? ak : st + ln;
      for (int k = 0; k <= last; k++) begin
         if (k > 0) begin @(posedge clock); #1; end
         if (ak != 0 && k == ak)
            chk_outputs("abort", IDLE_V, 1'b0, 1'b0, 1'b0, 1'b1);
         else if (k < st)
            chk_outputs("armed", IDLE_V, 1'b1, 1'b0, 1'b0, 1'b0);
         else if (k < st + ln)
            chk_outputs("inject", t, 1'b1, 1'b1, 1'b0, 1'b0);
         else begin
            if (exp_cnt < CMAX) exp_cnt++;
            chk_outputs("done", IDLE_V, 1'b0, 1'b0, 1'b1, 1'b0);
         end
         abort = (ak != 0 && ak == k + 1);
      end
      abort = 1'b0;
   endtask

   initial begin
      vecs[0] = '{32'd37,       3,  2, 0,  1'b0, 4,  2};
      vecs[1] = '{32'h1234,     0,  0, 0,  1'b1, 1,  1};
      vecs[2] = '{32'hABCD,     10, 5, 15, 1'b0, 11, 5};
      vecs[3] = '{IDLE_V,       1,  3, 0,  1'b0, 2,  3};
      vecs[4] = '{32'd5,        0,  1, 0,  1'b0, 1,  1};
      vecs[5] = '{32'd7,        2,  0, 3,  1'b0, 3,  1};
      vecs[6] = '{32'd9,        1,  2, 4,  1'b0, 2,  2};

      repeat (2) @(posedge clock);
      #1;
      chk_outputs("reset", IDLE_V, 1'b0, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      idle_cycles(5);

      foreach (vecs[i]) begin
         run_desc(vecs[i].target, vecs[i].delay, vecs[i].duration, vecs[i].abort_k,
                  vecs[i].abort0, vecs[i].exp_start, vecs[i].exp_len);
         idle_cycles(1);
      end

      for (int i = 0; i < 40; i++) begin
         logic [31:0] t;
         int d, du, st, ln, ak;
         t  = ($urandom % 8 == 0) ? IDLE_V : $urandom;
         d  = $urandom_range(0, 6);
         du = $urandom_range(0, 4);
         st = d + 1;
         ln = (du == 0) ? 1 : du;
         ak = ($urandom % 3 == 0) ? $urandom_range(1, st + ln) : 0;
         run_desc(t, d, du, ak, 1'($urandom % 4 == 0), st, ln);
         idle_cycles($urandom_range(0, 2));
      end

      // Asynchronous reset in the middle of an injection window.
      cfg_valid = 1'b1; cfg_target = 32'h55; cfg_delay = 32'd1; cfg_duration = 16'd6;
      @(posedge clock); #1;
      cfg_valid = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("pre-reset injecting", 32'(injecting), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      exp_cnt = 0;
      chk_outputs("async reset", IDLE_V, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clock); #1;
      chk_outputs("held reset", IDLE_V, 1'b0, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      run_desc(32'd77, 2, 3, 0, 1'b0, 3, 3);

      // Back-to-back one-cycle faults drive the counter into saturation.
      for (int i = 0; i < CMAX + 3; i++)
         run_desc(32'(i), 0, 1, 0, 1'b0, 1, 1);
      chk("saturated count", 32'(inject_count), 32'(CMAX));
      idle_cycles(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/verinject_fault_sequencer.md
# verinject_fault_sequencer

Programmable sequencer that generates the `verinject__injector_state` word consumed by every downstream verinject injector (memory-read and register injectors). A testbench or host loads one fault descriptor: target global bit index, delay in cycles, and duration in cycles. The block counts down the delay, drives the target index for exactly the requested number of cycles, then returns the bus to a no-fault value and reports completion. It is the single upstream source of injector state for the instrumented design.

## Interface
Parameters:
- `IDLE_STATE`, default 32'hFFFF_FFFF: value driven on the injector-state bus when no fault is active. Must lie outside every injector's `P_START` range.
- `DELAY_WIDTH`, default 32: width of the delay counter.
- `DUR_WIDTH`, default 16: width of the duration counter.
- `COUNT_WIDTH`, default 16: width of the completed-injection counter.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `cfg_valid`  in  1: descriptor on `cfg_*` is valid.
- `cfg_ready`  out  1: sequencer can accept a descriptor.
- `cfg_target`  in  32: global bit index to flip.
- `cfg_delay`  in  DELAY_WIDTH: cycles to wait before injecting.
- `cfg_duration`  in  DUR_WIDTH: injection window in cycles; 0 is treated as 1.
- `abort`  in  1: cancel the pending or active fault.
- `verinject__injector_state`  out  32: registered bus to the injectors.
- `busy`  out  1: state is ARMED or INJECTING.
- `injecting`  out  1: state is INJECTING.
- `done`  out  1: one-cycle pulse when a fault completes normally.
- `aborted`  out  1: one-cycle pulse when a fault is cancelled.
- `inject_count`  out  COUNT_WIDTH: completed injections, saturating.

## Operation
- States: IDLE, ARMED, INJECTING.
- IDLE:
  - `cfg_ready`=1.
  - On `cfg_valid & cfg_ready`, latch the descriptor, load `dly_cnt`=`cfg_delay`, and go to ARMED.
- ARMED:
  - Edge with `dly_cnt`==0: go to INJECTING and load `dur_cnt` = (`cfg_duration`==0) ? 0 : `cfg_duration`-1.
  - Otherwise decrement `dly_cnt`.
- INJECTING:
  - Edge with `dur_cnt`==0: go to IDLE, pulse `done`, and increment `inject_count` (saturating at all-ones).
  - Otherwise decrement `dur_cnt`.
- `abort` in ARMED or INJECTING: go to IDLE, pulse `aborted`, no `done`, count unchanged. Abort takes priority over every other transition on that edge.
- `abort` in IDLE is ignored; a simultaneous `cfg_valid` is accepted.
- `verinject__injector_state`:
  - Registered; equals the latched target while in INJECTING, `IDLE_STATE` otherwise.
  - Updated on the same edge as the state register, so there is no extra output latency.
- `cfg_target`==`IDLE_STATE` is accepted and sequenced normally. It is a functional no-op but still counts.
- `cfg_*` inputs are sampled only on the acceptance edge; later changes have no effect.
- Counter arithmetic is unsigned. No counter wraps: `dly_cnt`/`dur_cnt` stop at 0, and `inject_count` saturates.

## Timing
- Reset values:
  - State IDLE.
  - `verinject__injector_state`=`IDLE_STATE`.
  - `cfg_ready`=1.
  - `busy`, `injecting`, `done`, `aborted`=0.
  - `inject_count`=0.
  - Internal counters 0.
- Reset asserted mid-operation forces these values immediately, without waiting for a clock edge.
- Acceptance at edge E0:
  - The injection window starts at edge E0+D+1, where D=`cfg_delay`.
  - The window lasts exactly max(`cfg_duration`,1) cycles.
  - `done` is high for the first cycle back in IDLE.
- `cfg_ready` is high in that same cycle. Back-to-back descriptors therefore run with one IDLE cycle between windows.
- `busy` and `injecting` are combinational decodes of the state register.
- `done` and `aborted` are registered, never both high, and never high for two consecutive cycles from one descriptor.

## Test plan
- Reset, then idle 5 cycles → bus = 32'hFFFF_FFFF, `cfg_ready`=1, `inject_count`=0.
- Load target=37, delay=3, duration=2 at E0 → bus = 37 during cycles after E4 and E5. After E6: bus idle, `done`=1 for one cycle, `inject_count`=1.
- Load delay=0, duration=0 → bus = target for exactly one cycle after E1. `done` follows after E2.
- Load delay=10, duration=5; assert `abort` 4 cycles into INJECTING → bus returns idle on that edge, `aborted`=1 for one cycle, `done` never asserts, count unchanged.
- Assert `reset_n` low asynchronously (between clock edges) mid-INJECTING → bus idle and all outputs at reset values before the next clock edge. After release, a new descriptor is accepted normally.
- Force `inject_count` to 16'hFFFF via 65535 one-cycle faults (or a backdoor preload), then complete one more fault → count stays 16'hFFFF and `done` still pulses.
